// File: rtl/regbank_write_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter: FSM state encodings
// and default widths used by the interface, the arbiter and its round-robin picker.
package regbank_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam int DEF_NREQ   = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

endpackage

// File: rtl/regbank_write_arbiter_if.sv
// Requester-side and bank-side signals of the write arbiter, grouped into one bundle.
// The arbiter uses the slave modport; the requesters/bench drive the master modport.
interface regbank_write_arbiter_if
    import regbank_write_arbiter_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic                   clear_req;
    logic [NREQ-1:0]        gnt;
    logic                   we;
    logic [ADDR_W-1:0]      waddr;
    logic [DATA_W-1:0]      wdata;
    logic                   busy;
    logic                   clear_done;

    modport master (
        output req, req_addr, req_data, clear_req,
        input  gnt, we, waddr, wdata, busy, clear_done
    );

    modport slave (
        input  req, req_addr, req_data, clear_req,
        output gnt, we, waddr, wdata, busy, clear_done
    );
endinterface

// File: rtl/regbank_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, with
// wrap-around. Returns a one-hot grant, the winner index and an any-request flag.
module regbank_write_arbiter_rr_pick
    import regbank_write_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);
    logic [PTR_W-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NREQ);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end
endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin owner of the register bank's single write port, with a sequenced
// one-register-per-cycle bank clear. Every output comes straight from a flop.
module regbank_write_arbiter
    import regbank_write_arbiter_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input logic               clk,
    input logic               reset,
    regbank_write_arbiter_if.slave bus
);
    localparam int                PTR_W     = $clog2(NREQ);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_q, state_n;
    logic [NREQ-1:0]   gnt_q, gnt_n;
    logic              we_q, we_n;
    logic [ADDR_W-1:0] waddr_q, waddr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic              busy_q, busy_n;
    logic              clear_done_q, clear_done_n;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_n;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_n;
    logic              pend_q, pend_n;

    logic [NREQ-1:0]   pick_gnt;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_any;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    regbank_write_arbiter_rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr_q),
        .gnt    (pick_gnt),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Route the winner's address/data using the one-hot grant.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_n      = state_q;
        gnt_n        = '0;
        we_n         = 1'b0;
        waddr_n      = waddr_q;
        wdata_n      = wdata_q;
        busy_n       = 1'b0;
        clear_done_n = 1'b0;
        rr_ptr_n     = rr_ptr_q;
        clr_cnt_n    = clr_cnt_q;
        pend_n       = pend_q | bus.clear_req;
        unique case (state_q)
            ST_IDLE: begin
                // A pending or fresh clear always wins over the requesters.
                if (pend_q || bus.clear_req) begin
                    state_n   = ST_CLEAR;
                    we_n      = 1'b1;
                    waddr_n   = '0;
                    wdata_n   = '0;
                    clr_cnt_n = ADDR_W'(1);
                    busy_n    = 1'b1;
                    pend_n    = 1'b0;
                end else if (pick_any) begin
                    state_n  = ST_WRITE;
                    gnt_n    = pick_gnt;
                    we_n     = 1'b1;
                    waddr_n  = sel_addr;
                    wdata_n  = sel_data;
                    busy_n   = 1'b1;
                    rr_ptr_n = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + PTR_W'(1);
                end
            end
            ST_WRITE: begin
                state_n = ST_IDLE;
            end
            ST_CLEAR: begin
                if (waddr_q == LAST_ADDR) begin
                    state_n      = ST_IDLE;
                    clear_done_n = 1'b1;
                end else begin
                    we_n      = 1'b1;
                    waddr_n   = clr_cnt_q;
                    wdata_n   = '0;
                    clr_cnt_n = clr_cnt_q + ADDR_W'(1);
                    busy_n    = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
            rr_ptr_q     <= '0;
            clr_cnt_q    <= '0;
            pend_q       <= 1'b0;
        end else begin
            state_q      <= state_n;
            gnt_q        <= gnt_n;
            we_q         <= we_n;
            waddr_q      <= waddr_n;
            wdata_q      <= wdata_n;
            busy_q       <= busy_n;
            clear_done_q <= clear_done_n;
            rr_ptr_q     <= rr_ptr_n;
            clr_cnt_q    <= clr_cnt_n;
            pend_q       <= pend_n;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.we         = we_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign bus.busy       = busy_q;
    assign bus.clear_done = clear_done_q;
endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Scoreboard bench for regbank_write_arbiter: a transaction-level reference model
// predicts each cycle's outputs; a monitor compares them and models the DFF bank.
module tb_regbank_write_arbiter;
    import regbank_write_arbiter_pkg::*;

    localparam int NREQ   = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREG   = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } txn_t;

    typedef struct packed {
        logic [NREQ-1:0]   gnt;
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic              busy;
        logic              clear_done;
    } out_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regbank_write_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regbank_write_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    txn_t              backlog [NREQ][$];
    out_t              exp_q[$];
    int                gnt_log[$];
    logic [DATA_W-1:0] bank     [NREG];
    logic [DATA_W-1:0] exp_bank [NREG];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int last_gnt_cyc = 0;
    int we_cnt = 0;

    // Reference model state: mode 0=idle 1=write 2=clear, next clear address as a plain count.
    int   m_mode = 0;
    int   m_ptr  = 0;
    bit   m_pend = 1'b0;
    int   m_next = 0;
    out_t m_out  = '0;
    out_t mon_e, mon_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NREQ; i++) s += backlog[i].size();
        return s;
    endfunction

    function automatic void drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            if (backlog[i].size() > 0) begin
                bus.req[i] = 1'b1;
                bus.req_addr[i*ADDR_W +: ADDR_W] = backlog[i][0].addr;
                bus.req_data[i*DATA_W +: DATA_W] = backlog[i][0].data;
            end else begin
                bus.req[i] = 1'b0;
            end
        end
    endfunction

    function automatic void model_step();
        out_t e = m_out;
        int   w = -1;
        e.gnt = '0;
        e.we = 1'b0;
        e.busy = 1'b0;
        e.clear_done = 1'b0;
        if (reset) begin
            m_mode = 0; m_ptr = 0; m_pend = 1'b0; m_next = 0;
            e = '0;
        end else begin
            bit want_clear = m_pend || bus.clear_req;
            if (bus.clear_req) m_pend = 1'b1;
            case (m_mode)
                0: begin
                    if (want_clear) begin
                        m_mode = 2; m_pend = 1'b0; m_next = 1;
                        e.we = 1'b1; e.waddr = '0; e.wdata = '0; e.busy = 1'b1;
                    end else begin
                        for (int k = 0; k < NREQ; k++)
                            if (w < 0 && bus.req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                        if (w >= 0) begin
                            m_mode = 1;
                            e.gnt = NREQ'(1) << w;
                            e.we = 1'b1;
                            e.waddr = backlog[w][0].addr;
                            e.wdata = backlog[w][0].data;
                            e.busy = 1'b1;
                            m_ptr = (w + 1) % NREQ;
                        end
                    end
                end
                1: m_mode = 0;
                default: begin
                    if (m_next == NREG) begin
                        m_mode = 0;
                        e.clear_done = 1'b1;
                    end else begin
                        e.we = 1'b1; e.waddr = ADDR_W'(m_next); e.wdata = '0; e.busy = 1'b1;
                        m_next++;
                    end
                end
            endcase
        end
        if (e.we) exp_bank[e.waddr] = e.wdata;
        m_out = e;
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        txn_t t;
        drive_reqs();
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++)
            if (m_out.gnt[i]) t = backlog[i].pop_front();
        bus.clear_req = 1'b0;
    endtask

    task automatic drain(input int cap);
        int n = 0;
        while (pending() > 0 && n < cap) begin
            tick();
            n++;
        end
        check("drain_backlog", pending(), 0);
        tick();
        tick();
    endtask

    // Monitor: per-cycle scoreboard compare, grant logging and cleared-bank check.
    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {bus.gnt, bus.we, bus.waddr, bus.wdata, bus.busy, bus.clear_done};
            check("outputs{gnt,we,waddr,wdata,busy,done}", 32'(mon_a), 32'(mon_e));
        end
        if (bus.we === 1'b1) we_cnt++;
        if (bus.we === 1'b1 && bus.gnt !== '0) begin
            for (int k = 0; k < NREQ; k++)
                if (bus.gnt === (NREQ'(1) << k)) gnt_log.push_back(k);
            last_gnt_cyc = cyc;
        end
        if (bus.clear_done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
            for (int r = 0; r < NREG; r++) check("bank_zero_at_clear_done", 32'(bank[r]), 0);
        end
    end

    always @(posedge clk) begin
        if (bus.we === 1'b1) bank[bus.waddr] <= bus.wdata;
    end

    initial begin
        int d0;
        int we0;
        txn_t t;
        for (int r = 0; r < NREG; r++) begin
            bank[r] = '0;
            exp_bank[r] = '0;
        end
        bus.req = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.clear_req = 1'b0;

        // Reset with all four requesters asserting, two writes each.
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < 2; j++) begin
                t.addr = ADDR_W'(i * 2 + j);
                t.data = DATA_W'($urandom_range(1, 255));
                backlog[i].push_back(t);
            end
        reset = 1'b1;
        repeat (3) tick();
        check("reset_gnt", 32'(bus.gnt), 0);
        check("reset_we", 32'(bus.we), 0);
        check("reset_busy", 32'(bus.busy), 0);
        reset = 1'b0;
        gnt_log.delete();
        drain(100);
        check("rr_grant_count", gnt_log.size(), 8);
        for (int k = 0; k < 8 && k < gnt_log.size(); k++) check("rr_grant_order", gnt_log[k], k % NREQ);

        // Single requester 2 writes A5 to register 5.
        gnt_log.delete();
        t.addr = 3'd5; t.data = 8'hA5;
        backlog[2].push_back(t);
        drain(20);
        check("single_gnt_log", gnt_log.size() == 1 ? gnt_log[0] : -1, 2);
        check("bank5", 32'(bank[5]), 32'h0A5);

        // Clear pulsed during a WRITE; requesters 1 and 3 both waiting.
        gnt_log.delete();
        d0 = done_cnt;
        t.addr = 3'd6; t.data = 8'h3C; backlog[1].push_back(t);
        t.addr = 3'd2; t.data = 8'hC3; backlog[3].push_back(t);
        tick();
        bus.clear_req = 1'b1;
        drain(60);
        check("clear_done_pulses", done_cnt - d0, 1);
        check("clear_then_grants", gnt_log.size() == 2 ? gnt_log[0] * 10 + gnt_log[1] : -1, 31);
        for (int r = 0; r < NREG; r++) check("bank_after_clear", 32'(bank[r]), 32'(exp_bank[r]));

        // Reset while the sweep is at clr_cnt=3: sweep abandoned, nothing further written.
        d0 = done_cnt;
        bus.clear_req = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("midclear_reset_we", 32'(bus.we), 0);
        check("midclear_reset_done", 32'(bus.clear_done), 0);
        check("midclear_reset_busy", 32'(bus.busy), 0);
        reset = 1'b0;
        we0 = we_cnt;
        repeat (12) tick();
        check("no_writes_after_reset", we_cnt - we0, 0);
        check("no_done_after_reset", done_cnt - d0, 0);

        // Clear and requester 0 in the same IDLE cycle: sweep first, grant right after clear_done.
        gnt_log.delete();
        d0 = done_cnt;
        t.addr = 3'd1; t.data = 8'h5A; backlog[0].push_back(t);
        bus.clear_req = 1'b1;
        drain(40);
        check("same_cycle_done", done_cnt - d0, 1);
        check("same_cycle_grant", gnt_log.size() == 1 ? gnt_log[0] : -1, 0);
        check("grant_follows_done", last_gnt_cyc - last_done_cyc, 1);

        // Randomized traffic with occasional clears and resets.
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (backlog[i].size() < 3 && $urandom_range(0, 3) == 0) begin
                    t.addr = ADDR_W'($urandom);
                    t.data = DATA_W'($urandom);
                    backlog[i].push_back(t);
                end
            bus.clear_req = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 199) == 0);
            tick();
            reset = 1'b0;
        end
        drain(300);
        for (int r = 0; r < NREG; r++) check("bank_random", 32'(bank[r]), 32'(exp_bank[r]));
        @(negedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
